// File: rtl/signed_add_sat_pipe_if.sv
// Valid/ready operand and result streams for signed_add_sat_pipe.
// The master drives operands and result-ready; the slave is the adder.
interface signed_add_sat_pipe_if #(
  parameter int W = 8
);
  logic         arg_vld;
  logic         arg_rdy;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sat_en;
  logic         res_vld;
  logic         res_rdy;
  logic [W-1:0] sum;
  logic         overflow;

  modport master (
    output arg_vld, a, b, sat_en, res_rdy,
    input  arg_rdy, res_vld, sum, overflow
  );

  modport slave (
    input  arg_vld, a, b, sat_en, res_rdy,
    output arg_rdy, res_vld, sum, overflow
  );
endinterface

// File: rtl/signed_add_sat_pipe.sv
// Pipelined signed adder, wrap or saturate per transaction,
// with a sticky-at-max count of delivered overflow results.
module signed_add_sat_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  signed_add_sat_pipe_if.slave bus,
  input  logic                 ovf_cnt_clr,
  output logic [CNT_W-1:0]     ovf_cnt
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W:0]        s;
  logic              ovf;
  logic [W-1:0]      nsum;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] oq;
  logic [W-1:0]      sq [STAGES];
  logic              inc;

  always_comb begin
    s    = {bus.a[W-1], bus.a} + {bus.b[W-1], bus.b};
    ovf  = s[W] ^ s[W-1];
    nsum = s[W-1:0];
    if (ovf && bus.sat_en)
      nsum = bus.a[W-1] ? MINV : MAXV;
  end

  // Ready ripples back from the consumer; a hole anywhere downstream frees us.
  always_comb begin
    logic acc;
    acc = bus.res_rdy;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = ~vld[i] | acc;
      rdy[i] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      oq  <= '0;
      for (int i = 0; i < STAGES; i++)
        sq[i] <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= bus.arg_vld;
        if (bus.arg_vld) begin
          sq[0] <= nsum;
          oq[0] <= ovf;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            sq[i] <= sq[i-1];
            oq[i] <= oq[i-1];
          end
        end
      end
    end
  end

  assign bus.arg_rdy  = rdy[0];
  assign bus.res_vld  = vld[STAGES-1];
  assign bus.sum      = sq[STAGES-1];
  assign bus.overflow = oq[STAGES-1];

  assign inc = vld[STAGES-1] & bus.res_rdy & oq[STAGES-1];

  // Clear wins over the old count but not over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt <= '0;
    else if (ovf_cnt_clr)
      ovf_cnt <= inc ? CNT_W'(1) : '0;
    else if (inc && !(&ovf_cnt))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule
